// File: rtl/sum_normalize_round52.sv
// Purpose: leading-one normalise and round of the 52-bit mantissa sum to OUT_W bits; NORM_ROUND_RNE_EN selects RNE, else truncation.
// Latency: two register stages (S1 capture + LZC, S2 shift/round result); full rate with out_ready high.
// Backpressure: valid/ready on both sides; in_ready = !s1_vld | s1 advance, combinational from out_ready only.
module sum_normalize_round52 #(
  parameter int OUT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [51:0]      in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_mant,
  output logic [5:0]       out_msb_pos,
  output logic             out_zero,
  output logic             out_inexact
);

  logic        s1_vld;
  logic [51:0] s1_sum;
  logic [5:0]  s1_lz;
  logic        s1_zero;

  logic [5:0]  lz_c;
  logic        s2_load;
  logic        s1_adv;

  logic [51:0]      norm;
  logic [51:0]      sticky_bits;
  logic [OUT_W-1:0] mant_m;
  logic             guard_b;
  logic             sticky_b;
  logic [OUT_W-1:0] mant_c;
  logic [5:0]       msb_c;

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    lz_c = 6'd52;
    for (int i = 0; i < 52; i++) begin
      if (in_sum[i]) lz_c = 6'(51 - i);
    end
  end

  assign s2_load  = !out_valid | out_ready;
  assign s1_adv   = s1_vld & s2_load;
  assign in_ready = !s1_vld | s1_adv;

  always_comb begin
    norm        = s1_sum << s1_lz;
    mant_m      = norm[51 -: OUT_W];
    guard_b     = norm[51-OUT_W];
    // Shifting out the mantissa and guard leaves exactly the sticky bits.
    sticky_bits = norm << (OUT_W + 1);
    sticky_b    = |sticky_bits;
  end

`ifdef NORM_ROUND_RNE_EN
  logic             rnd_inc;
  logic [OUT_W:0]   rnd_sum;

  assign rnd_inc = guard_b & (sticky_b | mant_m[0]);
  assign rnd_sum = {1'b0, mant_m} + {{OUT_W{1'b0}}, rnd_inc};

  always_comb begin
    mant_c = rnd_sum[OUT_W-1:0];
    msb_c  = 6'd51 - s1_lz;
    if (rnd_sum[OUT_W]) begin
      mant_c = {1'b1, {(OUT_W-1){1'b0}}};
      msb_c  = 6'd52 - s1_lz;
    end
    if (s1_zero) msb_c = 6'd0;
  end
`else
  always_comb begin
    mant_c = mant_m;
    msb_c  = s1_zero ? 6'd0 : 6'd51 - s1_lz;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld      <= 1'b0;
      s1_sum      <= '0;
      s1_lz       <= '0;
      s1_zero     <= 1'b0;
      out_valid   <= 1'b0;
      out_mant    <= '0;
      out_msb_pos <= '0;
      out_zero    <= 1'b0;
      out_inexact <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_vld <= in_valid;
        if (in_valid) begin
          s1_sum  <= in_sum;
          s1_lz   <= lz_c;
          s1_zero <= (in_sum == '0);
        end
      end
      // Result fields only change on a real S1->S2 move, so they hold under stall.
      if (s2_load) begin
        out_valid <= s1_vld;
        if (s1_vld) begin
          out_mant    <= mant_c;
          out_msb_pos <= msb_c;
          out_zero    <= s1_zero;
          out_inexact <= guard_b | sticky_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_sum_normalize_round52.sv
// Bench for sum_normalize_round52 (OUT_W=24): directed and random words through a model-fed scoreboard.
module tb_sum_normalize_round52;

  typedef struct packed {
    logic [23:0] mant;
    logic [5:0]  msb;
    logic        zero;
    logic        inex;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [51:0] in_sum;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_mant;
  logic [5:0]  out_msb_pos;
  logic        out_zero;
  logic        out_inexact;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_acc  = 0;
  bit   rnd_done;
  exp_t sb_q[$];

  sum_normalize_round52 #(.OUT_W(24)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_msb_pos(out_msb_pos),
    .out_zero(out_zero), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [51:0] x);
    exp_t        e;
    int          p;
    logic [51:0] n;
    logic [23:0] m;
    logic        g;
    logic        s;
    e = '0;
    if (x == 52'd0) begin
      e.zero = 1'b1;
      return e;
    end
    p = 0;
    for (int i = 0; i < 52; i++) if (x[i]) p = i;
    n = x << (51 - p);
    m = n[51:28];
    g = n[27];
    s = |n[26:0];
    e.mant = m;
    e.msb  = 6'(p);
    e.inex = g | s;
`ifdef NORM_ROUND_RNE_EN
    if (g && (s || m[0])) begin
      if (m == 24'hFFFFFF) begin
        e.mant = 24'h800000;
        e.msb  = 6'(p + 1);
      end else begin
        e.mant = m + 24'd1;
      end
    end
`endif
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the word is taken (in_valid left high).
  task automatic send(input logic [51:0] x, input exp_t e);
    bit acc;
    int budget;
    in_valid = 1'b1;
    in_sum   = x;
    budget   = 0;
    acc      = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready && !rst;
      if (acc) begin
        sb_q.push_back(e);
        n_acc++;
      end
      @(posedge clk);
      #1;
      budget++;
      if (!acc && budget > 200) begin
        check("send_timeout", 64'(budget), 64'(0));
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [51:0] rand_sum();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    if ($urandom_range(0, 15) == 0) return 52'd0;
    return r[51:0] >> $urandom_range(0, 51);
  endfunction

  // Output side scoreboard: compared every cycle a result is presented, popped on handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else if (sb_q.size() == 0) begin
      check("spurious_valid", 64'(out_valid), 64'(0));
    end else if (out_valid) begin
      check("mant", 64'(out_mant), 64'(sb_q[0].mant));
      check("msb_pos", 64'(out_msb_pos), 64'(sb_q[0].msb));
      check("zero", 64'(out_zero), 64'(sb_q[0].zero));
      check("inexact", 64'(out_inexact), 64'(sb_q[0].inex));
      if (out_ready) void'(sb_q.pop_front());
    end
  end

  initial begin
    exp_t e_carry;
    exp_t e_tie_up;
    int   base;
    int   guard;

`ifdef NORM_ROUND_RNE_EN
    e_carry  = '{mant: 24'h800000, msb: 6'd52, zero: 1'b0, inex: 1'b1};
    e_tie_up = '{mant: 24'h800002, msb: 6'd51, zero: 1'b0, inex: 1'b1};
`else
    e_carry  = '{mant: 24'hFFFFFF, msb: 6'd51, zero: 1'b0, inex: 1'b1};
    e_tie_up = '{mant: 24'h800001, msb: 6'd51, zero: 1'b0, inex: 1'b1};
`endif

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_mant", 64'(out_mant), 64'(0));
    check("rst_msb_pos", 64'(out_msb_pos), 64'(0));
    check("rst_zero", 64'(out_zero), 64'(0));
    check("rst_inexact", 64'(out_inexact), 64'(0));
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Directed words with hand-derived results.
    send(52'h0,             '{mant: 24'h0,      msb: 6'd0,  zero: 1'b1, inex: 1'b0});
    send(52'h8000000000000, '{mant: 24'h800000, msb: 6'd51, zero: 1'b0, inex: 1'b0});
    send(52'h1,             '{mant: 24'h800000, msb: 6'd0,  zero: 1'b0, inex: 1'b0});
    send(52'hFFFFFF8000000, e_carry);
    send(52'h8000018000000, e_tie_up);
    send(52'h8000008000000, '{mant: 24'h800000, msb: 6'd51, zero: 1'b0, inex: 1'b1});
    send(52'h0000000ABCDEF, '{mant: 24'hABCDEF, msb: 6'd23, zero: 1'b0, inex: 1'b0});
    idle(4);
    check("directed_drained", 64'(sb_q.size()), 64'(0));

    // Backpressure: five back-to-back words against a 4-cycle stall.
    out_ready = 1'b0;
    base = n_acc;
    fork
      begin
        logic [51:0] x;
        for (int k = 0; k < 5; k++) begin
          x = rand_sum();
          send(x, model(x));
        end
        in_valid = 1'b0;
      end
    join_none
    repeat (4) @(posedge clk);
    #1;
    check("bp_accepts", 64'(n_acc - base), 64'(2));
    check("bp_in_ready", 64'(in_ready), 64'(0));
    check("bp_out_valid", 64'(out_valid), 64'(1));
    out_ready = 1'b1;
    wait fork;
    idle(4);
    check("bp_drained", 64'(sb_q.size()), 64'(0));

    // Reset with a full pipeline discards both words.
    out_ready = 1'b0;
    send(52'h123456789ABCD, model(52'h123456789ABCD));
    send(52'h0F0F0F0F0F0F0, model(52'h0F0F0F0F0F0F0));
    idle(1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    rst = 1'b0;
    out_ready = 1'b1;
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    idle(3);
    check("midrst_no_ghost", 64'(out_valid), 64'(0));

    // Random words with random gaps and random out_ready.
    rnd_done = 1'b0;
    fork
      begin
        logic [51:0] x;
        for (int k = 0; k < 60; k++) begin
          x = rand_sum();
          send(x, model(x));
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        guard = 0;
        while (!rnd_done && guard < 3000) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
          guard++;
        end
        out_ready = 1'b1;
      end
    join

    guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("final_drained", 64'(sb_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
